edge_qualifier: RTL and testbench
=================================

EDGE_QUALIFIER -- requirements
Module: edge_qualifier

Interface
REQ-001 SHALL provide parameter STABLE_CYCLES, default 4, as the consecutive equal samples needed to accept a level change; legal range 1..254.
REQ-002 SHALL provide port clk, input, 1, the single clock; all state updates on posedge clk.
REQ-003 SHALL provide port reset_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL provide port in_data, input, 1, raw level input (pre-synchronized unless the REQ-021 macro is defined).
REQ-005 SHALL provide port out_level, output, 1, qualified (debounced) level.
REQ-006 SHALL provide port rise_pulse, output, 1, one-cycle strobe on each accepted 0->1 change.
REQ-007 SHALL provide port fall_pulse, output, 1, one-cycle strobe on each accepted 1->0 change.
REQ-008 SHALL provide port busy, output, 1, high while a candidate change is being qualified.
REQ-009 SHALL provide port glitch_cnt, output, 8, saturating count of rejected candidate changes.

Function
REQ-010 SHALL implement four states: LOW, QUAL_HIGH, HIGH, QUAL_LOW; all outputs registered.
REQ-011 SHALL, in LOW on a high sample, enter QUAL_HIGH with run counter 1; in HIGH on a low sample, enter QUAL_LOW with run counter 1.
REQ-012 SHALL, in QUAL_HIGH, increment the run counter per high sample and, on the posedge taking the STABLE_CYCLES-th consecutive high sample, enter HIGH, set out_level 1, assert rise_pulse.
REQ-013 SHALL, in QUAL_LOW, mirror REQ-012 for low samples, clearing out_level and asserting fall_pulse.
REQ-014 SHALL, on an opposite sample during QUAL_HIGH/QUAL_LOW, return to LOW/HIGH respectively, clear the run counter, emit no pulse, leave out_level unchanged, and increment glitch_cnt.
REQ-015 SHALL saturate glitch_cnt at 255; no wrap.
REQ-016 SHALL hold rise_pulse and fall_pulse high exactly one cycle each; never both high in the same cycle.
REQ-017 SHALL, with STABLE_CYCLES=1, bypass qualify states: out_level and the pulse update on the posedge sampling the change; busy stays 0; glitch_cnt stays 0.
REQ-018 SHALL drive busy 1 exactly while in QUAL_HIGH or QUAL_LOW.
REQ-019 SHALL, on a change accepted while in_data immediately reverses, start a new qualification on the next sample without losing the pulse already emitted.

Reset
REQ-020 SHALL, while reset_n is 0, asynchronously force state LOW, run counter 0, out_level 0, rise_pulse 0, fall_pulse 0, busy 0, glitch_cnt 0, synchronizer flops 0; any qualification in progress is abandoned without a pulse or glitch count; after release, a high in_data qualifies normally from LOW.

Configuration
REQ-021 SHALL, when macro EDGE_QUALIFIER_SYNC_EN is defined, insert a two-flop posedge synchronizer on in_data ahead of the state machine, adding exactly 2 cycles of latency to every response; when undefined, in_data feeds the state machine directly and must be synchronous to clk.

Verification (STABLE_CYCLES=4, macro undefined unless stated)
REQ-022 SHALL cover: reset_n=0 with in_data=1 -> out_level=0, pulses=0, busy=0, glitch_cnt=0.
REQ-023 SHALL cover: in_data 0->1 sampled first at posedge 10, held -> busy=1 after posedges 10..12, rise_pulse=1 and out_level=1 after posedge 13 only, busy=0.
REQ-024 SHALL cover: from LOW, in_data high for 2 samples then low -> no rise_pulse, out_level=0, glitch_cnt=1; repeated 300 times -> glitch_cnt=255.
REQ-025 SHALL cover: from HIGH, in_data low 4 samples -> one fall_pulse after 4th low sample, out_level=0; low 3 samples then high -> no pulse, glitch_cnt+1.
REQ-026 SHALL cover: reset_n pulsed low after 2 qualifying high samples, in_data held high -> no pulse during reset; rise_pulse after the 4th high sample post-release.
REQ-027 SHALL cover: EDGE_QUALIFIER_SYNC_EN defined, stimulus of REQ-023 -> rise_pulse after posedge 15.

Source files
------------

// File: rtl/edge_qualifier.sv
// Debounces a single-bit level: a change is accepted only after STABLE_CYCLES equal samples.
// Optional macro EDGE_QUALIFIER_SYNC_EN adds a two-flop input synchronizer (two cycles of latency).
module edge_qualifier #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       in_data,
    output logic       out_level,
    output logic       rise_pulse,
    output logic       fall_pulse,
    output logic       busy,
    output logic [7:0] glitch_cnt,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        LOW       = 2'd0,
        QUAL_HIGH = 2'd1,
        HIGH      = 2'd2,
        QUAL_LOW  = 2'd3
    } state_t;

    // The sample that completes qualification is the one taken while run_cnt holds STABLE_CYCLES-1.
    localparam logic [7:0] LAST_RUN = 8'(STABLE_CYCLES - 1);
    localparam bit         BYPASS   = (STABLE_CYCLES == 1);

    state_t     state, state_next;
    logic [7:0] run_cnt, run_cnt_next;
    logic       sample;
    logic       accept_rise, accept_fall, reject;
    logic       out_level_next, rise_next, fall_next, busy_next;
    logic [7:0] glitch_next;

`ifdef EDGE_QUALIFIER_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sync_q <= 2'b00;
        else          sync_q <= {sync_q[0], in_data};
    end

    assign sample = sync_q[1];
`else
    assign sample = in_data;
`endif

    // State register; every output is registered alongside the state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= LOW;
            run_cnt    <= 8'd0;
            out_level  <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
            busy       <= 1'b0;
            glitch_cnt <= 8'd0;
        end else begin
            state      <= state_next;
            run_cnt    <= run_cnt_next;
            out_level  <= out_level_next;
            rise_pulse <= rise_next;
            fall_pulse <= fall_next;
            busy       <= busy_next;
            glitch_cnt <= glitch_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next   = state;
        run_cnt_next = run_cnt;
        accept_rise  = 1'b0;
        accept_fall  = 1'b0;
        reject       = 1'b0;
        case (state)
            LOW: begin
                if (sample) begin
                    if (BYPASS) begin
                        state_next  = HIGH;
                        accept_rise = 1'b1;
                    end else begin
                        state_next   = QUAL_HIGH;
                        run_cnt_next = 8'd1;
                    end
                end
            end
            QUAL_HIGH: begin
                if (!sample) begin
                    state_next   = LOW;
                    run_cnt_next = 8'd0;
                    reject       = 1'b1;
                end else if (run_cnt == LAST_RUN) begin
                    state_next   = HIGH;
                    run_cnt_next = 8'd0;
                    accept_rise  = 1'b1;
                end else begin
                    run_cnt_next = run_cnt + 8'd1;
                end
            end
            HIGH: begin
                if (!sample) begin
                    if (BYPASS) begin
                        state_next  = LOW;
                        accept_fall = 1'b1;
                    end else begin
                        state_next   = QUAL_LOW;
                        run_cnt_next = 8'd1;
                    end
                end
            end
            QUAL_LOW: begin
                if (sample) begin
                    state_next   = HIGH;
                    run_cnt_next = 8'd0;
                    reject       = 1'b1;
                end else if (run_cnt == LAST_RUN) begin
                    state_next   = LOW;
                    run_cnt_next = 8'd0;
                    accept_fall  = 1'b1;
                end else begin
                    run_cnt_next = run_cnt + 8'd1;
                end
            end
            default: begin
                state_next   = LOW;
                run_cnt_next = 8'd0;
            end
        endcase
    end

    // Output logic: values loaded into the output registers on the next edge.
    always_comb begin
        out_level_next = out_level;
        if (accept_rise) out_level_next = 1'b1;
        if (accept_fall) out_level_next = 1'b0;
        rise_next   = accept_rise;
        fall_next   = accept_fall;
        busy_next   = (state_next == QUAL_HIGH) || (state_next == QUAL_LOW);
        glitch_next = glitch_cnt;
        if (reject && (glitch_cnt != 8'hFF)) glitch_next = glitch_cnt + 8'd1;
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_edge_qualifier.sv
// Scoreboard bench for edge_qualifier: each driven sample pushes the expected outputs for that sample.
module tb_edge_qualifier;
    localparam int W = 12;
`ifdef EDGE_QUALIFIER_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       in_data = 1'b0;
    logic       out_level, rise_pulse, fall_pulse, busy;
    logic [7:0] glitch_cnt;
    logic [1:0] dbg_state;

    logic [W-1:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int exp_g = 0;

    edge_qualifier #(.STABLE_CYCLES(4)) dut (
        .clk(clk), .reset_n(reset_n), .in_data(in_data),
        .out_level(out_level), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
        .busy(busy), .glitch_cnt(glitch_cnt), .dbg_state(dbg_state)
    );

    // Clock and posedge counter (cyc == k right after posedge k).
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete, cyc=%0d", cyc);
        $fatal(1);
    end

    function automatic logic [W-1:0] ev(input logic ol, input logic r, input logic f,
                                        input logic b, input int g);
        return {ol, r, f, b, 8'(g)};
    endfunction

    function automatic logic [W-1:0] observe();
        return {out_level, rise_pulse, fall_pulse, busy, glitch_cnt};
    endfunction

    // Driver: apply one sample, record its expected response, sample outputs 1 time unit after the edge.
    task automatic step(input logic d, input logic [W-1:0] e);
        in_data = d;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [W-1:0] got;
        reset_n = 1'b0;
        in_data = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            got = observe();
            n_vec++;
            if (got !== '0 || dbg_state !== 2'd0) begin
                n_err++;
                $display("FAIL reset cycle %0d: got %b state %0d, want all zero", i, got, dbg_state);
            end
        end
        in_data = 1'b0;
        reset_n = 1'b1;
        exp_q.delete();
        exp_g = 0;
        for (int i = 0; i < 2; i++) begin
            logic [W-1:0] e;
            step(1'b0, ev(0, 0, 0, 0, 0));
            if (exp_q.size() > LAT) begin
                e = exp_q.pop_front(); got = observe(); n_vec++;
                if (got !== e) begin n_err++; $display("FAIL idle_after_reset %0d: got %b want %b", i, got, e); end
            end
        end
    endtask

    task automatic test_rise();
        logic [W-1:0] e, got;
        while (cyc < 9) begin
            step(1'b0, ev(0, 0, 0, 0, exp_g));
            if (exp_q.size() > LAT) begin
                e = exp_q.pop_front(); got = observe(); n_vec++;
                if (got !== e) begin n_err++; $display("FAIL rise_idle cyc %0d: got %b want %b", cyc, got, e); end
            end
        end
        // First high sample lands on posedge 10; acceptance on posedge 13.
        for (int i = 0; i < 6; i++) begin
            if (i < 3)       e = ev(0, 0, 0, 1, exp_g);
            else if (i == 3) e = ev(1, 1, 0, 0, exp_g);
            else             e = ev(1, 0, 0, 0, exp_g);
            step(1'b1, e);
            if (exp_q.size() > LAT) begin
                e = exp_q.pop_front(); got = observe(); n_vec++;
                if (got !== e) begin n_err++; $display("FAIL rise cyc %0d: got %b want %b", cyc, got, e); end
            end
        end
    endtask

    task automatic test_fall();
        logic         d_pat[10];
        logic [W-1:0] e, got;
        d_pat = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
        for (int i = 0; i < 10; i++) begin
            if (i < 3)       e = ev(1, 0, 0, 1, exp_g);
            else if (i == 3) begin exp_g++; e = ev(1, 0, 0, 0, exp_g); end
            else if (i < 7)  e = ev(1, 0, 0, 1, exp_g);
            else if (i == 7) e = ev(0, 0, 1, 0, exp_g);
            else             e = ev(0, 0, 0, 0, exp_g);
            step(d_pat[i], e);
            if (exp_q.size() > LAT) begin
                e = exp_q.pop_front(); got = observe(); n_vec++;
                if (got !== e) begin n_err++; $display("FAIL fall step %0d: got %b want %b", i, got, e); end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic         d_pat[11];
        logic [W-1:0] e_pat[11];
        logic [W-1:0] e, got;
        d_pat = '{1, 1, 1, 1, 0, 0, 0, 0, 1, 0, 0};
        e_pat = '{ev(0, 0, 0, 1, exp_g), ev(0, 0, 0, 1, exp_g), ev(0, 0, 0, 1, exp_g),
                  ev(1, 1, 0, 0, exp_g),
                  ev(1, 0, 0, 1, exp_g), ev(1, 0, 0, 1, exp_g), ev(1, 0, 0, 1, exp_g),
                  ev(0, 0, 1, 0, exp_g),
                  ev(0, 0, 0, 1, exp_g),
                  ev(0, 0, 0, 0, exp_g + 1), ev(0, 0, 0, 0, exp_g + 1)};
        exp_g++;
        for (int i = 0; i < 11; i++) begin
            step(d_pat[i], e_pat[i]);
            if (exp_q.size() > LAT) begin
                e = exp_q.pop_front(); got = observe(); n_vec++;
                if (got !== e) begin n_err++; $display("FAIL back_to_back step %0d: got %b want %b", i, got, e); end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] e, got;
        for (int i = 0; i < 2; i++) begin
            step(1'b1, ev(0, 0, 0, 1, exp_g));
            if (exp_q.size() > LAT) begin
                e = exp_q.pop_front(); got = observe(); n_vec++;
                if (got !== e) begin n_err++; $display("FAIL reset_mid_pre %0d: got %b want %b", i, got, e); end
            end
        end
        reset_n = 1'b0;
        exp_q.delete();
        exp_g = 0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            got = observe(); n_vec++;
            if (got !== '0) begin n_err++; $display("FAIL reset_mid_hold %0d: got %b want 0", i, got); end
        end
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i < 3)       e = ev(0, 0, 0, 1, 0);
            else if (i == 3) e = ev(1, 1, 0, 0, 0);
            else             e = ev(1, 0, 0, 0, 0);
            step(1'b1, e);
            if (exp_q.size() > LAT) begin
                e = exp_q.pop_front(); got = observe(); n_vec++;
                if (got !== e) begin n_err++; $display("FAIL reset_mid_post %0d: got %b want %b", i, got, e); end
            end
        end
        // Return to LOW cleanly before the glitch test.
        for (int i = 0; i < 5; i++) begin
            if (i < 3)       e = ev(1, 0, 0, 1, 0);
            else if (i == 3) e = ev(0, 0, 1, 0, 0);
            else             e = ev(0, 0, 0, 0, 0);
            step(1'b0, e);
            if (exp_q.size() > LAT) begin
                e = exp_q.pop_front(); got = observe(); n_vec++;
                if (got !== e) begin n_err++; $display("FAIL reset_mid_fall %0d: got %b want %b", i, got, e); end
            end
        end
    endtask

    task automatic test_glitch_saturate();
        logic [W-1:0] e, got;
        for (int r = 0; r < 300; r++) begin
            for (int k = 0; k < 3; k++) begin
                if (k < 2) e = ev(0, 0, 0, 1, exp_g);
                else begin
                    exp_g = (exp_g == 255) ? 255 : exp_g + 1;
                    e = ev(0, 0, 0, 0, exp_g);
                end
                step((k < 2) ? 1'b1 : 1'b0, e);
                if (exp_q.size() > LAT) begin
                    e = exp_q.pop_front(); got = observe(); n_vec++;
                    if (got !== e) begin n_err++; $display("FAIL glitch rep %0d k %0d: got %b want %b", r, k, got, e); end
                end
            end
            // Randomly spaced idle samples between glitches.
            for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
                step(1'b0, ev(0, 0, 0, 0, exp_g));
                if (exp_q.size() > LAT) begin
                    e = exp_q.pop_front(); got = observe(); n_vec++;
                    if (got !== e) begin n_err++; $display("FAIL glitch_idle rep %0d: got %b want %b", r, got, e); end
                end
            end
        end
        for (int i = 0; i < LAT + 2; i++) begin
            step(1'b0, ev(0, 0, 0, 0, 255));
            if (exp_q.size() > LAT) begin
                e = exp_q.pop_front(); got = observe(); n_vec++;
                if (got !== e) begin n_err++; $display("FAIL glitch_sat %0d: got %b want %b", i, got, e); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_rise();
        test_fall();
        test_back_to_back();
        test_reset_mid();
        test_glitch_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
